muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits between the register file read ports (operands from RD1/RD2) and the write-back path (WE3/A3/WD3).
- Core control stalls on busy and commits the result when done pulses.
- Handles all eight M-extension operations with a fixed shift-add / restoring-divide datapath.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported; the counter width is derived as log2(XLEN).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; accepted only when busy=0
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (dividend / multiplicand)
- op_b  input  XLEN  rs2 value (divisor / multiplier)
- rd_in  input  5  destination register index
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result and rd_out valid
- result  output  XLEN  final value
- rd_out  output  5  captured rd_in, drives A3
- wb_we  output  1  equals done, drives WE3

Behaviour:
- Reset:
  - rst sampled high at a clock edge forces state IDLE.
  - busy, done, wb_we, result, rd_out, counter and internal accumulators all go to 0.
  - Applies mid-operation: the operation is abandoned and no done is issued.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, capture funct3, rd_in, |op_a|, |op_b| (magnitude taken only for signed operands per op), the sign flags, and clear the counter.
  - Normal case: go to CALC.
  - Special case: go straight to FIX.
- CALC: one iteration per cycle, counter 0..31; at counter==31 go to FIX.
- Multiply iteration (shift-add):
  - 64-bit product accumulator.
  - If the multiplier LSB is 1, add the multiplicand into the upper half.
  - Shift right by 1.
- Divide iteration (restoring):
  - Shift {rem, quot} left by 1.
  - If rem >= divisor, subtract and set the quotient LSB.
- FIX: apply sign correction and select the output, then go to DONE.
  - MUL: low 32 bits of product.
  - MULH/MULHSU/MULHU: high 32 bits.
  - Product is negated when the operand signs differ; MULHSU treats op_b as unsigned.
  - DIV: quotient, negated when signs differ.
  - REM: remainder, taking the sign of the dividend.
- DONE: done=1, wb_we=1, result and rd_out stable; next state is IDLE.
- result and rd_out hold their value after DONE until the next FIX.
- Latency:
  - Normal ops: start high in cycle 0; CALC cycles 1..32, FIX cycle 33, done in cycle 34.
  - Special cases: done in cycle 2.
- Special cases (bypass CALC):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a unchanged.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- start while busy=1, including in the DONE cycle: ignored, no capture.
- Operands may change after the start cycle without effect.
- rd_in=0: computed normally; wb_we still pulses (the register file discards x0 writes).
- Arithmetic is modulo 2^XLEN / 2^(2*XLEN); no exceptions and no flags.

Decomposition:
- Shared package muldiv_pkg holds:
  - XLEN
  - funct3 encodings as named constants
  - FSM state encoding (2 bits)
  - ITER_LAST = XLEN-1
- One natural sub-module: muldiv_sign, a combinational conditional two's-complement negate, used for operand magnitude in IDLE and result correction in FIX.
- The iteration datapath and FSM stay in muldiv_unit.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> done exactly in cycle 34, result=0xFFFFFFEB, rd_out=rd_in, wb_we=1 for one cycle only.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
- DIV 0x1234/0 -> 0xFFFFFFFF, REM 0x1234/0 -> 0x1234, DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each with done in cycle 2.
- Second start pulsed in cycle 10 with different operands -> ignored; the first result is unchanged at cycle 34, and busy is continuous from cycle 1 to 34.
- rst asserted in cycle 15 of a DIVU -> next cycle busy=0, result=0, no done pulse; a new start in the following cycle completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
// Holds the operand width, funct3 encodings, iteration bound and FSM state encoding.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(XLEN - 1);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for sign correction of the final product, quotient or remainder.
module muldiv_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  always_comb begin
    result = negate ? (~value + W'(1)) : value;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and
// restoring divide sharing one 64-bit accumulator, with sign fix-up at the end.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_we
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;

  logic [2:0]        op;
  logic [4:0]        rd_q;
  logic              sign_a;
  logic              sign_b;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  count;

  logic              a_signed;
  logic              b_signed;
  logic              neg_a_in;
  logic              neg_b_in;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              is_special;
  logic [XLEN-1:0]   special_in;

  // Operand decode at issue: which operands are signed and whether CALC can be skipped.
  always_comb begin
    a_signed   = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    b_signed   = a_signed && (funct3 != F3_MULHSU);
    neg_a_in   = a_signed && op_a[XLEN-1];
    neg_b_in   = b_signed && op_b[XLEN-1];
    div_zero   = funct3[2] && (op_b == '0);
    div_ovf    = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
    is_special = div_zero || div_ovf;
    special_in = '0;
    if (div_zero) begin
      special_in = funct3[1] ? op_a : '1;
    end else if (div_ovf) begin
      special_in = funct3[1] ? '0 : INT_MIN;
    end
  end

  muldiv_sign #(.W(XLEN)) u_mag_a (
    .value  (op_a),
    .negate (neg_a_in),
    .result (mag_a)
  );

  muldiv_sign #(.W(XLEN)) u_mag_b (
    .value  (op_b),
    .negate (neg_b_in),
    .result (mag_b)
  );

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;
  logic [2*XLEN-1:0] acc_step;

  // One iteration: acc holds {product} for multiply or {rem, quot} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    rem_shift = acc[2*XLEN-1:XLEN-1];
    rem_diff  = rem_shift - {1'b0, opnd};
    acc_step  = '0;
    if (op[2]) begin
      acc_step = {acc[2*XLEN-2:0], 1'b0};
      if (rem_shift >= {1'b0, opnd}) begin
        acc_step[2*XLEN-1:XLEN] = rem_diff[XLEN-1:0];
        acc_step[0]             = 1'b1;
      end
    end else if (acc[0]) begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end else begin
      acc_step = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] fix_in;
  logic              fix_neg;
  logic [2*XLEN-1:0] fix_val;
  logic [XLEN-1:0]   fix_sel;

  // Remainder follows the dividend's sign; product and quotient negate on sign mismatch.
  always_comb begin
    fix_in  = acc;
    fix_neg = sign_a ^ sign_b;
    if (op[2]) begin
      if (op[1]) begin
        fix_in  = {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]};
        fix_neg = sign_a;
      end else begin
        fix_in  = {{XLEN{1'b0}}, acc[XLEN-1:0]};
      end
    end
  end

  muldiv_sign #(.W(2*XLEN)) u_fix (
    .value  (fix_in),
    .negate (fix_neg),
    .result (fix_val)
  );

  always_comb begin
    fix_sel = fix_val[XLEN-1:0];
    if (!op[2] && (op != F3_MUL)) begin
      fix_sel = fix_val[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    wb_we      = done;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = is_special ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (count == ITER_LAST) begin
          state_next = S_FIX;
        end
      end
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op          <= '0;
      rd_q        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      special     <= 1'b0;
      special_res <= '0;
      opnd        <= '0;
      acc         <= '0;
      count       <= '0;
      result      <= '0;
      rd_out      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op          <= funct3;
            rd_q        <= rd_in;
            sign_a      <= neg_a_in;
            sign_b      <= neg_b_in;
            special     <= is_special;
            special_res <= special_in;
            count       <= '0;
            opnd        <= funct3[2] ? mag_b : mag_a;
            acc         <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
          end
        end
        S_CALC: begin
          acc   <= acc_step;
          count <= count + 1'b1;
        end
        S_FIX: begin
          result <= special ? special_res : fix_sel;
          rd_out <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wb_we;

  int errors = 0;
  int checks = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .wb_we  (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic isSpecial(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 32'd0) return 1'b1;
    if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // RV32M semantics using wide native arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f3)
      3'b000: begin p = 64'(sa * sb); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = sa / sb;
        return q[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Present one request for exactly one clock, then scramble the operand inputs.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    rd_in  = 5'($urandom);
    funct3 = 3'($urandom);
  endtask

  // Issue an op, watch every cycle up to two past the expected done, then check outputs.
  task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int intrCycle, input string tag);
    int          firstDone;
    int          pulses;
    int          busyGap;
    int          weErr;
    int          expLat;
    logic [31:0] expRes;
    firstDone = -1;
    pulses    = 0;
    busyGap   = 0;
    weErr     = 0;
    expRes    = refModel(f3, a, b);
    expLat    = isSpecial(f3, a, b) ? 2 : 34;
    applyStimulus(f3, a, b, rd);
    for (int c = 1; c <= expLat + 2; c++) begin
      if (c == intrCycle) begin
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd999;
        op_b   = 32'd5;
        rd_in  = rd ^ 5'h1F;
      end else if (c == intrCycle + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        pulses++;
        if (firstDone < 0) firstDone = c;
      end
      if (wb_we !== done) weErr++;
      if (c <= expLat && busy !== 1'b1) busyGap++;
      @(negedge clk);
    end
    checkOutput({tag, "_lat"}, 64'(firstDone), 64'(expLat));
    checkOutput({tag, "_pulses"}, 64'(pulses), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busyGap), 64'd0);
    checkOutput({tag, "_we"}, 64'(weErr), 64'd0);
    checkOutput({tag, "_res"}, 64'(result), 64'(expRes));
    checkOutput({tag, "_rd"}, 64'(rd_out), 64'(rd));
  endtask

  initial begin
    int          dones;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_we", 64'(wb_we), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_rd", 64'(rd_out), 64'd0);
    rst = 1'b0;

    runOp(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, -1, "mul");
    runOp(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, -1, "mulh");
    runOp(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, -1, "mulhu");
    runOp(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, -1, "mulhsu");
    runOp(3'b101, 32'd100, 32'd7, 5'd9, -1, "divu");
    runOp(3'b111, 32'd100, 32'd7, 5'd10, -1, "remu");
    runOp(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11, -1, "div_neg");
    runOp(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd12, -1, "rem_neg");
    runOp(3'b100, 32'h1234, 32'd0, 5'd13, -1, "div_zero");
    runOp(3'b110, 32'h1234, 32'd0, 5'd14, -1, "rem_zero");
    runOp(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, -1, "div_ovf");
    runOp(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, -1, "rem_ovf");
    runOp(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd0, -1, "mul_x0");
    runOp(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 10, "busy_ignore");
    runOp(3'b111, 32'hDEAD_BEEF, 32'd0, 5'd17, 1, "special_ignore");

    // Abort a DIVU mid-calculation with reset, then confirm the unit restarts cleanly.
    applyStimulus(3'b101, 32'd1000, 32'd3, 5'd4);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_result", 64'(result), 64'd0);
    checkOutput("midrst_rd", 64'(rd_out), 64'd0);
    dones = 0;
    repeat (40) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 64'(dones), 64'd0);
    runOp(3'b101, 32'd1000, 32'd3, 5'd4, -1, "after_rst");

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(15));
        default: ;
      endcase
      runOp(rf3, ra, rb, 5'($urandom), -1, $sformatf("rand%0d_f%0d", i, rf3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
